ctrl_word_executor: RTL and testbench
=====================================

Name: ctrl_word_executor

Overview:
- Datapath-side consumer of the control words that the sequencer FSMs in this chapter produce: op_sel, en_x, en_y, y_sel.
- Accepts control words plus an immediate over a valid/ready handshake and buffers them in a small FIFO.
- Retires one word per cycle into the X/Y register pair through a 4-function ALU.
- Exposes X, Y, status flags and a retire counter so a controller or bench can observe results.

Parameters:
- W, 8, data width of X, Y, immediate and ALU
- DEPTH, 4, command FIFO depth (power of two, >=2)
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command word present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_op_sel  in  2  ALU function (see Behaviour)
- cmd_en_x  in  1  write X with ALU result
- cmd_en_y  in  1  write Y
- cmd_y_sel  in  1  Y source: 1 = immediate, 0 = ALU result
- cmd_imm  in  W  immediate for Y
- exec_en  in  1  allow retirement; low stalls execution, intake continues
- flush  in  1  synchronous discard of all buffered commands
- x_out  out  W  X register
- y_out  out  W  Y register
- zero  out  1  X == 0
- neg  out  1  X[W-1]
- retired  out  1  one-cycle pulse per retired command
- retire_cnt  out  CNT_W  total retired commands, wraps
- fifo_level  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (reset low, asynchronous):
  - X, Y, retire_cnt, FIFO pointers and level are 0; retired is 0.
  - cmd_ready is 1 after reset release; zero = 1, neg = 0.
- Handshake:
  - A word is accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready depends only on registered occupancy; it does not depend combinationally on same-cycle pop.
  - At full, cmd_ready = 0 even if a retire occurs that cycle.
  - The sender must hold a word stable while valid && !ready.
- Pop and execute:
  - The head word retires on an edge where the FIFO is non-empty && exec_en && !flush.
  - Minimum latency: a word accepted at edge N updates X/Y at edge N+1.
  - Push into an empty FIFO never retires in the same cycle.
- Control states: IDLE (empty or exec_en = 0) and RUN (non-empty and exec_en = 1). The state is derived from the registered level, with no separate state register required.
- ALU: A = X, B = Y, result R of width W.
  - op 0: R = A (hold)
  - op 1: R = ~A
  - op 2: R = A + B, modulo 2^W, carry discarded
  - op 3: R = B
- Register writes on retirement:
  - If en_x: X <= R.
  - If en_y: Y <= (y_sel ? imm : R).
  - Both may be written in one word; both use pre-edge X/Y values.
  - en_x = en_y = 0 is a legal NOP: it still retires and still counts.
- Flush:
  - FIFO becomes empty next edge; no retirement that cycle.
  - A push in the same cycle is dropped.
  - X, Y and retire_cnt are unaffected.
- Simultaneous push and pop (not full): level is unchanged, and the pushed word lands behind the popped one.
- retire_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-stream discards all buffered words.

Optional Feature:
- Macro CWE_OVF_FLAG_EN.
- When defined:
  - Adds outputs carry (1) and ovf (1), both registered.
  - They update only on retirement of an op-2 word with en_x.
  - carry = carry out of A+B; ovf = signed overflow (A, B same sign, R different).
  - Other retirements hold them; both reset to 0.
- When undefined: the ports and logic are absent, and op 2 behaviour is otherwise identical.

Decomposition:
- Shared package cwe_pkg:
  - op_sel encodings OP_HOLD=0, OP_NOT=1, OP_ADD=2, OP_PASSB=3.
  - Packed command-word typedef {op_sel, en_x, en_y, y_sel, imm}.
- One sub-module, cwe_cmd_fifo: synchronous FIFO with level, flush and full/empty flags, parameterised by width and DEPTH.
- ALU and register logic stay in the top level.

Test Plan:
- Additive-inverse sequence (W=8, exec_en=1):
  - Stimulus: y<=imm5 (y_sel=1, en_y), x<=y (op3, en_x), x<=~x (op1), y<=imm1, x<=x+y (op2).
  - Response: x_out=0xFB, neg=1, zero=0, retire_cnt=5.
  - Continue with y<=imm5, x<=x+y: response x_out=0x00, zero=1, retire_cnt=7.
- Backpressure:
  - Stimulus: exec_en=0, push 5 words.
  - Response: 4 accepted, cmd_ready=0 at level 4, fifth word held by sender.
  - Then exec_en=1: response is 5 retirements in order, one retired pulse per cycle.
- Latency: single push into an empty FIFO at edge N -> X updates at edge N+1, not N.
- Flush: 3 words buffered, flush plus push together -> level=0 next cycle, pushed word dropped, X/Y unchanged, no retired pulse.
- Async reset mid-stream: reset low between edges -> outputs zero immediately, cmd_ready=1 after release, buffered words gone.
- With CWE_OVF_FLAG_EN: X=0x7F, Y=0x01, op2 -> x_out=0x80, ovf=1, carry=0. Then X=0xFF, Y=0x01, op2 -> x_out=0x00, carry=1, ovf=0.

Source files
------------

// File: rtl/cwe_pkg.sv
// Shared types for the control-word executor: ALU op encodings, the control
// fields of a command word and the derived IDLE/RUN control state.
package cwe_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_NOT   = 2'd1,
    OP_ADD   = 2'd2,
    OP_PASSB = 2'd3
  } cwe_op_e;

  // Control half of a command word; the W-bit immediate is appended by the top.
  typedef struct packed {
    cwe_op_e op_sel;
    logic    en_x;
    logic    en_y;
    logic    y_sel;
  } cwe_ctrl_t;

  localparam int CWE_CTRL_W = $bits(cwe_ctrl_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cwe_state_e;

endpackage

// File: rtl/ctrl_word_executor_if.sv
// Command intake bus. valid/ready: a word transfers on a rising clk edge where
// valid && ready; the master holds all fields stable while valid && !ready.
interface ctrl_word_executor_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [1:0]   op_sel;
  logic         en_x;
  logic         en_y;
  logic         y_sel;
  logic [W-1:0] imm;

  modport master (output valid, output op_sel, output en_x, output en_y,
                  output y_sel, output imm, input ready);
  modport slave  (input valid, input op_sel, input en_x, input en_y,
                  input y_sel, input imm, output ready);
endinterface

// File: rtl/cwe_cmd_fifo.sv
// Synchronous command FIFO with occupancy level and synchronous flush.
// Flush wins over push and pop in the same cycle.
module cwe_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ctrl_word_executor.sv
// Buffers control words and retires one per cycle into X/Y through a 4-op ALU.
// Optional carry/ovf flags on ADD are enabled by defining CWE_OVF_FLAG_EN.
module ctrl_word_executor
  import cwe_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ctrl_word_executor_if.slave  cmd,
  input  logic                 exec_en,
  input  logic                 flush,
  output logic [W-1:0]         x_out,
  output logic [W-1:0]         y_out,
  output logic                 zero,
  output logic                 neg,
  output logic                 retired,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [LW-1:0]        fifo_level,
  output cwe_state_e           dbg_state
`ifdef CWE_OVF_FLAG_EN
  ,
  output logic                 carry,
  output logic                 ovf
`endif
);

  typedef struct packed {
    cwe_ctrl_t    ctrl;
    logic [W-1:0] imm;
  } cmd_word_t;

  localparam int CW = $bits(cmd_word_t);

  cmd_word_t        push_word, head;
  logic             fifo_full, fifo_empty;
  logic             do_retire;
  logic [W-1:0]     x_q, x_d, y_q, y_d, alu_r;
  logic [W:0]       sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retired_q;

  always_comb begin
    push_word             = '0;
    push_word.ctrl.op_sel = cwe_op_e'(cmd.op_sel);
    push_word.ctrl.en_x   = cmd.en_x;
    push_word.ctrl.en_y   = cmd.en_y;
    push_word.ctrl.y_sel  = cmd.y_sel;
    push_word.imm         = cmd.imm;
  end

  cwe_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd.valid),
    .pop_i   (do_retire),
    .flush_i (flush),
    .din_i   (push_word),
    .dout_o  (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign cmd.ready = !fifo_full;

  assign dbg_state = (!fifo_empty && exec_en) ? ST_RUN : ST_IDLE;
  assign do_retire = (dbg_state == ST_RUN) && !flush;

  always_comb begin
    sum   = {1'b0, x_q} + {1'b0, y_q};
    alu_r = x_q;
    case (head.ctrl.op_sel)
      OP_HOLD:  alu_r = x_q;
      OP_NOT:   alu_r = ~x_q;
      OP_ADD:   alu_r = sum[W-1:0];
      OP_PASSB: alu_r = y_q;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    if (do_retire) begin
      if (head.ctrl.en_x) x_d = alu_r;
      if (head.ctrl.en_y) y_d = head.ctrl.y_sel ? head.imm : alu_r;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      retired_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      retired_q <= do_retire;
    end
  end

`ifdef CWE_OVF_FLAG_EN
  logic carry_q, carry_d, ovf_q, ovf_d;

  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (do_retire && head.ctrl.en_x && (head.ctrl.op_sel == OP_ADD)) begin
      carry_d = sum[W];
      ovf_d   = (x_q[W-1] == y_q[W-1]) && (sum[W-1] != x_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry = carry_q;
  assign ovf   = ovf_q;
`endif

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign zero       = (x_q == '0);
  assign neg        = x_q[W-1];
  assign retired    = retired_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_word_executor.sv
// Directed bench for ctrl_word_executor with a queue-based reference model
// checked every cycle; covers the carry/ovf flags when CWE_OVF_FLAG_EN is set.
module tb_ctrl_word_executor;
  import cwe_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             exec_en;
  logic             flush;
  logic [W-1:0]     x_out, y_out;
  logic             zero, neg, retired;
  logic [CNT_W-1:0] retire_cnt;
  logic [LW-1:0]    fifo_level;
  cwe_state_e       dbg_state;
`ifdef CWE_OVF_FLAG_EN
  logic             carry, ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_word_executor_if #(.W(W)) cmd_if ();

  ctrl_word_executor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .exec_en    (exec_en),
    .flush      (flush),
    .x_out      (x_out),
    .y_out      (y_out),
    .zero       (zero),
    .neg        (neg),
    .retired    (retired),
    .retire_cnt (retire_cnt),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
`ifdef CWE_OVF_FLAG_EN
    ,
    .carry      (carry),
    .ovf        (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Word packing: {op[1:0], en_x, en_y, y_sel, imm[7:0]}
  logic [W+4:0]     exp_q[$];
  logic [W-1:0]     mx, my;
  logic [CNT_W-1:0] mcnt;
  logic             mret, mcarry, movf;

  always @(posedge clk or negedge reset) begin
    logic         acc, ret;
    logic [W+4:0] w;
    int           r, a, b;
    if (!reset) begin
      exp_q.delete();
      mx = '0; my = '0; mcnt = '0; mret = 1'b0; mcarry = 1'b0; movf = 1'b0;
    end else begin
      acc  = cmd_if.valid && (exp_q.size() < DEPTH) && !flush;
      ret  = (exp_q.size() > 0) && exec_en && !flush;
      mret = ret;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (ret) begin
          w = exp_q.pop_front();
          a = int'(mx);
          b = int'(my);
          case (w[12:11])
            2'd0: r = a;
            2'd1: r = 255 - a;
            2'd2: r = a + b;
            default: r = b;
          endcase
          if (w[10] && w[12:11] == 2'd2) begin
            mcarry = (r > 255);
            movf   = (a >= 128) == (b >= 128) && ((r % 256) >= 128) != (a >= 128);
          end
          if (w[10]) mx = W'(r % 256);
          if (w[9])  my = w[8] ? w[7:0] : W'(r % 256);
          mcnt = mcnt + 1'b1;
        end
        if (acc) exp_q.push_back({cmd_if.op_sel, cmd_if.en_x, cmd_if.en_y,
                                  cmd_if.y_sel, cmd_if.imm});
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("x_out",      32'(x_out),      32'(mx));
    chk("y_out",      32'(y_out),      32'(my));
    chk("zero",       32'(zero),       32'(mx == 0));
    chk("neg",        32'(neg),        32'(mx[W-1]));
    chk("retired",    32'(retired),    32'(mret));
    chk("retire_cnt", 32'(retire_cnt), 32'(mcnt));
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("cmd_ready",  32'(cmd_if.ready), 32'(exp_q.size() < DEPTH));
    chk("state",      32'(dbg_state),  32'((exp_q.size() > 0) && exec_en));
`ifdef CWE_OVF_FLAG_EN
    chk("carry",      32'(carry),      32'(mcarry));
    chk("ovf",        32'(ovf),        32'(movf));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive_word(input logic [1:0] op, input logic ex, input logic ey,
                            input logic ys, input logic [W-1:0] imm);
    cmd_if.op_sel = op;
    cmd_if.en_x   = ex;
    cmd_if.en_y   = ey;
    cmd_if.y_sel  = ys;
    cmd_if.imm    = imm;
    cmd_if.valid  = 1'b1;
  endtask

  // Holds the word until it transfers; returns one negedge+1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic ex, input logic ey,
                      input logic ys, input logic [W-1:0] imm);
    logic rdy;
    int   n;
    n = 0;
    drive_word(op, ex, ey, ys, imm);
    forever begin
      rdy = cmd_if.ready;
      tick(1);
      if (rdy) break;
      n++;
      if (n > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got not-ready for %0d cycles expected ready", n);
        break;
      end
    end
    cmd_if.valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (fifo_level != 0 && k < 60) begin
      tick(1);
      k++;
    end
    chk("drain", 32'(fifo_level), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset        = 1'b0;
    exec_en      = 1'b0;
    flush        = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.op_sel = '0; cmd_if.en_x = 0; cmd_if.en_y = 0; cmd_if.y_sel = 0; cmd_if.imm = '0;
    #1;
    chk("rst_x",     32'(x_out), 32'h0);
    chk("rst_zero",  32'(zero), 32'h1);
    chk("rst_neg",   32'(neg), 32'h0);
    chk("rst_ready", 32'(cmd_if.ready), 32'h1);
    chk("rst_cnt",   32'(retire_cnt), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // additive inverse: x = ~5 + 1 = -5, then + 5 = 0
    exec_en = 1'b1;
    send(2'd0, 0, 1, 1, 8'd5);
    send(2'd3, 1, 0, 0, 8'd0);
    send(2'd1, 1, 0, 0, 8'd0);
    send(2'd0, 0, 1, 1, 8'd1);
    send(2'd2, 1, 0, 0, 8'd0);
    wait_empty();
    chk("inv_x",    32'(x_out), 32'hFB);
    chk("inv_neg",  32'(neg), 32'h1);
    chk("inv_zero", 32'(zero), 32'h0);
    chk("inv_cnt",  32'(retire_cnt), 32'd5);
    send(2'd0, 0, 1, 1, 8'd5);
    send(2'd2, 1, 0, 0, 8'd0);
    wait_empty();
    chk("sum0_x",    32'(x_out), 32'h00);
    chk("sum0_zero", 32'(zero), 32'h1);
    chk("sum0_cnt",  32'(retire_cnt), 32'd7);

    // backpressure: fifth word held by sender until a slot frees
    exec_en = 1'b0;
    send(2'd0, 0, 1, 1, 8'h11);
    send(2'd0, 0, 1, 1, 8'h22);
    send(2'd0, 0, 1, 1, 8'h33);
    send(2'd0, 0, 1, 1, 8'h44);
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_ready", 32'(cmd_if.ready), 32'd0);
    fork
      send(2'd0, 0, 1, 1, 8'h55);
      begin
        tick(3);
        chk("bp_hold_level", 32'(fifo_level), 32'd4);
        exec_en = 1'b1;
      end
    join
    wait_empty();
    chk("bp_y",   32'(y_out), 32'h55);
    chk("bp_cnt", 32'(retire_cnt), 32'd12);

    // latency: accepted at edge N, X changes at N+1
    send(2'd1, 1, 0, 0, 8'd0);
    chk("lat_x_before", 32'(x_out), 32'h00);
    chk("lat_level",    32'(fifo_level), 32'd1);
    tick(1);
    chk("lat_x_after",  32'(x_out), 32'hFF);
    chk("lat_retired",  32'(retired), 32'd1);
    chk("lat_cnt",      32'(retire_cnt), 32'd13);

    // flush with simultaneous push
    exec_en = 1'b0;
    send(2'd1, 1, 0, 0, 8'd0);
    send(2'd0, 0, 1, 1, 8'h77);
    send(2'd1, 1, 0, 0, 8'd0);
    chk("fl_level_pre", 32'(fifo_level), 32'd3);
    drive_word(2'd0, 0, 1, 1, 8'h99);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    cmd_if.valid = 1'b0;
    chk("fl_level",   32'(fifo_level), 32'd0);
    chk("fl_x",       32'(x_out), 32'hFF);
    chk("fl_y",       32'(y_out), 32'h55);
    chk("fl_retired", 32'(retired), 32'd0);
    exec_en = 1'b1;
    tick(3);
    chk("fl_cnt", 32'(retire_cnt), 32'd13);

    // NOPs still count; counter wraps 15 -> 0
    for (int i = 0; i < 5; i++) send(2'd0, 0, 0, 0, 8'(i));
    wait_empty();
    chk("wrap_cnt", 32'(retire_cnt), 32'd2);
    chk("nop_x",    32'(x_out), 32'hFF);

    // asynchronous reset between edges
    exec_en = 1'b0;
    send(2'd1, 1, 0, 0, 8'd0);
    send(2'd0, 0, 1, 1, 8'h12);
    chk("ar_level_pre", 32'(fifo_level), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_x",     32'(x_out), 32'h0);
    chk("ar_y",     32'(y_out), 32'h0);
    chk("ar_zero",  32'(zero), 32'h1);
    chk("ar_cnt",   32'(retire_cnt), 32'h0);
    chk("ar_level", 32'(fifo_level), 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    chk("ar_ready", 32'(cmd_if.ready), 32'h1);
    exec_en = 1'b1;
    tick(3);
    chk("ar_cnt_after", 32'(retire_cnt), 32'h0);
    chk("ar_x_after",   32'(x_out), 32'h0);

`ifdef CWE_OVF_FLAG_EN
    send(2'd0, 0, 1, 1, 8'h7F);
    send(2'd3, 1, 0, 0, 8'd0);
    send(2'd0, 0, 1, 1, 8'h01);
    send(2'd2, 1, 0, 0, 8'd0);
    wait_empty();
    chk("ovf1_x",     32'(x_out), 32'h80);
    chk("ovf1_ovf",   32'(ovf), 32'h1);
    chk("ovf1_carry", 32'(carry), 32'h0);
    send(2'd0, 0, 1, 1, 8'hFF);
    send(2'd3, 1, 0, 0, 8'd0);
    send(2'd0, 0, 1, 1, 8'h01);
    send(2'd2, 1, 0, 0, 8'd0);
    wait_empty();
    chk("ovf2_x",     32'(x_out), 32'h00);
    chk("ovf2_carry", 32'(carry), 32'h1);
    chk("ovf2_ovf",   32'(ovf), 32'h0);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
